// File: rtl/dif_chain.sv
// dif_chain: shared engine for difference orders 1..ORDER over stride STRIDE, with saturation, warm-up validity and overrun
//   clk, rst_n        : 100 MHz clock, asynchronous active-low reset
//   en_dif, clr       : sample strobe (with current_data), synchronous clear
//   dif_data          : packed results, order k in [k*OUT_W-1:(k-1)*OUT_W]
//   dif_valid         : per-order warm-up complete
//   sat_flag, overrun : sticky saturation per order, sticky busy-strobe drop
//   dif_finish        : one-cycle pulse when all orders are updated
module dif_chain #(
    parameter int DATA_W = 13,
    parameter int OUT_W  = 13,
    parameter int ORDER  = 3,
    parameter int STRIDE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_dif,
    input  logic                     clr,
    input  logic signed [DATA_W-1:0] current_data,
    output logic [ORDER*OUT_W-1:0]   dif_data,
    output logic [ORDER-1:0]         dif_valid,
    output logic [ORDER-1:0]         sat_flag,
    output logic                     overrun,
    output logic                     dif_finish
);
    localparam int XW = (DATA_W > OUT_W ? DATA_W : OUT_W) + 1;
    localparam int PW = STRIDE > 1 ? $clog2(STRIDE) : 1;
    localparam int KW = ORDER > 1 ? $clog2(ORDER) : 1;
    localparam int CW = $clog2(ORDER * STRIDE + 2);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t r_state, w_next;
    logic signed [OUT_W-1:0] r_hist [ORDER][STRIDE];
    logic signed [OUT_W-1:0] r_res [ORDER];
    logic signed [OUT_W-1:0] r_cur, w_hist, w_sat;
    logic signed [XW-1:0]    w_x_ext, w_diff;
    logic [KW-1:0]           r_k;
    logic [PW-1:0]           r_ptr;
    logic [CW-1:0]           r_cnt;
    logic [ORDER*OUT_W-1:0]  r_data;
    logic [ORDER-1:0]        r_valid, r_sat, w_vnew;
    logic                    r_ovr, w_last;
    function automatic logic ovf(input logic [XW-1:0] v);
        return !(&v[XW-1:OUT_W-1] || ~|v[XW-1:OUT_W-1]);
    endfunction
    function automatic logic [OUT_W-1:0] sat(input logic [XW-1:0] v);
        return ovf(v) ? (v[XW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}}) : v[OUT_W-1:0];
    endfunction
    always_comb begin
        w_x_ext = {{(XW-DATA_W){current_data[DATA_W-1]}}, current_data};
        w_hist  = r_hist[r_k][r_ptr];
        w_diff  = {{(XW-OUT_W){r_cur[OUT_W-1]}}, r_cur} - {{(XW-OUT_W){w_hist[OUT_W-1]}}, w_hist};
        w_sat   = sat(w_diff);
        w_last  = 32'(r_k) == ORDER - 1;
        // order k is valid once the sample being computed is number k*S+1 or later
        for (int i = 0; i < ORDER; i++) w_vnew[i] = 32'(r_cnt) + 1 >= (i + 1) * STRIDE + 1;
        w_next = clr ? IDLE :
                 r_state == IDLE ? (en_dif ? CALC : IDLE) :
                 r_state == CALC ? (w_last ? DONE : CALC) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist  <= '{default: '0};
            r_res   <= '{default: '0};
            r_cur   <= '0;
            r_k     <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= '0;
            r_sat   <= '0;
            r_ovr   <= 1'b0;
        end else if (clr) begin
            r_hist  <= '{default: '0};
            r_res   <= '{default: '0};
            r_cur   <= '0;
            r_k     <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= '0;
            r_sat   <= '0;
            r_ovr   <= 1'b0;
        end else begin
            if (en_dif && r_state != IDLE) r_ovr <= 1'b1;
            if (en_dif && r_state == IDLE) begin
                r_cur <= sat(w_x_ext);
                r_k   <= '0;
            end
            if (r_state == CALC) begin
                // the saturated result becomes the next stage's current value
                r_hist[r_k][r_ptr] <= r_cur;
                r_cur              <= w_sat;
                r_res[r_k]         <= w_sat;
                r_k                <= r_k + 1'b1;
                if (ovf(w_diff) && w_vnew[r_k]) r_sat[r_k] <= 1'b1;
                // publish all orders together, timed to appear with dif_finish
                if (w_last) begin
                    for (int i = 0; i < ORDER; i++)
                        r_data[i*OUT_W +: OUT_W] <= w_vnew[i] ? (i == int'(r_k) ? w_sat : r_res[i]) : '0;
                    r_valid <= w_vnew;
                end
            end
            if (r_state == DONE) begin
                r_ptr <= 32'(r_ptr) == STRIDE - 1 ? '0 : r_ptr + 1'b1;
                r_cnt <= 32'(r_cnt) == ORDER * STRIDE + 1 ? r_cnt : r_cnt + 1'b1;
            end
        end
    end
    assign dif_data   = r_data;
    assign dif_valid  = r_valid;
    assign sat_flag   = r_sat;
    assign overrun    = r_ovr;
    assign dif_finish = r_state == DONE;
endmodule

// File: doc/dif_chain.md
Name: dif_chain

Overview:
- Parametrised successor to the separate first/second/third difference blocks.
- One shared engine computes difference orders 1..ORDER over a configurable sample stride. It adds saturation, per-order warm-up validity and overrun detection.
- Sits between kalman_filter (filtered_data) and neck_judge. It is strobed by the ADC/filter completion pulse and runs on clk_100m.

Parameters:
- DATA_W, 13: signed input sample width.
- OUT_W, 13: signed output width per order; all stage results are saturated to this width.
- ORDER, 3: highest difference order, 1..6.
- STRIDE, 1: sample spacing S of each difference, 1..8. d_k[n] = d_(k-1)[n] - d_(k-1)[n-S], with d_0 = x.

Ports:
- clk  in  1  system clock (100 MHz domain).
- rst_n  in  1  asynchronous active-low reset.
- en_dif  in  1  single-cycle sample strobe; current_data is valid in the same cycle.
- clr  in  1  synchronous clear of history, warm-up counter and sticky flags.
- current_data  in  DATA_W  signed input sample.
- dif_data  out  ORDER*OUT_W  packed results; order k occupies bits [k*OUT_W-1:(k-1)*OUT_W].
- dif_valid  out  ORDER  bit k-1 is high once order k has full history.
- sat_flag  out  ORDER  sticky; bit k-1 is set when an order-k result has saturated.
- overrun  out  1  sticky; set when en_dif arrives while the engine is busy.
- dif_finish  out  1  one-cycle pulse when all orders for the current sample are updated.

Behaviour:
- Reset (async, rst_n=0): all history registers, dif_data, dif_valid, sat_flag, overrun and dif_finish are cleared to 0. The FSM goes to IDLE and the sample counter goes to 0. Reset mid-calculation aborts the calculation; no dif_finish is produced.
- Input handling: the input is sign-extended (or saturated if DATA_W > OUT_W) to OUT_W and stored as stage 0.
- History buffer: each stage 0..ORDER-1 keeps a circular history of S entries with one shared write pointer. The pointer wraps S-1 -> 0.
- FSM states:
  - IDLE: on en_dif, latch current_data and go to CALC with k=1.
  - CALC: one cycle per order. Compute d_k = cur_(k-1) - hist_(k-1)[ptr] at OUT_W+1 bits. Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1], then write hist_(k-1)[ptr] <= cur_(k-1). When k==ORDER, go to DONE; otherwise k <= k+1.
  - DONE: write hist_ORDER-level state, advance ptr mod S, increment the sample counter (saturating at ORDER*S+1), pulse dif_finish, return to IDLE.
- Latency: en_dif at cycle t gives dif_finish at t+ORDER+1. dif_data changes only in the dif_finish cycle; all orders update together and hold between samples.
- Warm-up: dif_valid[k-1] rises in the dif_finish cycle of accepted sample number k*S+1. While an order is invalid, its dif_data field is forced to 0 and its saturation is not flagged.
- Saturation: sets sat_flag[k-1], which holds until clr or reset. The saturated value is also the value stored into the next stage's history.
- Busy strobe: en_dif while not IDLE (including the DONE cycle) sets overrun and the sample is dropped. The in-flight calculation is unaffected.
- clr precedence: clr has priority over en_dif in the same cycle. clr in IDLE clears history, counter, dif_valid, dif_data and flags. clr while busy aborts the calculation (no dif_finish) and clears the same state.
- Back-to-back: en_dif in the cycle after dif_finish is accepted. The sustained rate is one sample per ORDER+2 cycles.

Test Plan:
- Ramp, defaults (ORDER=3, S=1): x=0,5,10,15,20 -> at sample 2 d1=5 and dif_valid=001. At sample 4 d1=5, d2=0, d3=0 and dif_valid=111. dif_finish comes 4 cycles after each en_dif.
- Quadratic x=n^2: 0,1,4,9,16 -> after sample 5, d1=7, d2=2, d3=0.
- Saturation, OUT_W=13: x=-4096 then 4095 -> d1=4095 (clipped from 8191) and sat_flag=001. A following x=4095 gives d1=0 and d2=-4095 (0-4095), not saturated; sat_flag stays 001 until clr.
- Stride (S=2, ORDER=2): x=0,10,20,30,40 -> d1 becomes valid at sample 3 with value 20. d2 becomes valid at sample 5 with value 0. The ptr wraps correctly.
- Overrun: en_dif at t and t+2 -> overrun=1, exactly one dif_finish at t+4, and results reflect only the first sample.
- Reset/clr mid-operation: assert rst_n=0 at t+2 after en_dif -> all outputs are 0 immediately and there is no dif_finish. Repeat with clr -> same clearing; the next sample behaves as the first after reset (dif_valid=000).
